// File: rtl/batch_dispatcher.sv
// Batch dispatcher: buffers one conflict-free batch, issues each entry to the lowest free
// worker lane, and holds the next batch back until every lane of the current one reports done.
module batch_dispatcher #(
    parameter int MAX_BATCH_SIZE = 8,
    parameter int NUM_WORKERS    = 4,
    parameter int WID_W          = $clog2(NUM_WORKERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [63:0]            s_axis_tdata_owner_programID,
    input  logic                   s_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [63:0]            m_axis_tdata_owner_programID,
    output logic [WID_W-1:0]       m_axis_tdata_worker_id,
    input  logic [NUM_WORKERS-1:0] worker_done,
    output logic [NUM_WORKERS-1:0] worker_busy,
    output logic                   batch_in_flight,
    output logic [31:0]            batches_dispatched,
    output logic [31:0]            txns_dispatched,
    output logic [31:0]            dispatch_stall_cycles,
    output logic [31:0]            forced_closes
);

    localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1);
    localparam int IDX_W = (MAX_BATCH_SIZE > 1) ? $clog2(MAX_BATCH_SIZE) : 1;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [63:0]            r_buf [MAX_BATCH_SIZE];
    logic [CNT_W-1:0]       r_wr_idx;
    logic [CNT_W-1:0]       r_rd_idx;
    logic [CNT_W-1:0]       r_count;
    logic [NUM_WORKERS-1:0] r_busy;
    logic                   r_hold;
    logic [WID_W-1:0]       r_hold_wid;
    logic [31:0]            r_batches;
    logic [31:0]            r_txns;
    logic [31:0]            r_stall;
    logic [31:0]            r_forced;

    logic [NUM_WORKERS-1:0] w_free;
    logic [WID_W-1:0]       w_low_wid;
    logic [WID_W-1:0]       w_wid;
    logic                   w_dispatching;
    logic                   w_mvalid;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic                   w_last_wr;
    logic                   w_last_rd;
    logic                   w_close;
    logic                   w_stall;
    logic                   w_drain_done;
    logic [NUM_WORKERS-1:0] w_set;
    logic [NUM_WORKERS-1:0] w_busy_next;

    assign w_free        = ~r_busy;
    assign w_dispatching = (r_state == DISPATCH);
    assign s_axis_tready = (r_state == FILL) && rst_n;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_last_wr     = (r_wr_idx == CNT_W'(MAX_BATCH_SIZE - 1));
    assign w_close       = w_in_hs && (s_axis_tlast || w_last_wr);
    assign w_last_rd     = (r_rd_idx == (r_count - 1'b1));

    // Lowest-index free lane; scanning downward lets the lowest set bit win.
    always_comb begin
        w_low_wid = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_low_wid = WID_W'(i);
            end
        end
    end

    // Once an offer is pending, the held lane wins even if a lower lane frees up.
    assign w_wid        = r_hold ? r_hold_wid : w_low_wid;
    assign w_mvalid     = w_dispatching && (r_hold || (w_free != '0));
    assign w_out_hs     = w_mvalid && m_axis_tready;
    assign w_stall      = w_dispatching && ((w_free == '0) || (w_mvalid && !m_axis_tready));
    assign w_drain_done = (r_state == DRAIN) && (r_busy == '0);

    assign m_axis_tvalid                = w_mvalid;
    assign m_axis_tdata_worker_id       = w_mvalid ? w_wid : '0;
    assign m_axis_tdata_owner_programID = w_mvalid ? r_buf[r_rd_idx[IDX_W-1:0]] : '0;

    assign worker_busy           = r_busy;
    assign batch_in_flight       = (r_state == DISPATCH) || (r_state == DRAIN);
    assign batches_dispatched    = r_batches;
    assign txns_dispatched       = r_txns;
    assign dispatch_stall_cycles = r_stall;
    assign forced_closes         = r_forced;

    always_comb begin
        w_set = '0;
        if (w_out_hs) begin
            w_set[w_wid] = 1'b1;
        end
        w_busy_next = (r_busy & ~worker_done) | w_set;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:     if (w_close) w_state_next = DISPATCH;
            DISPATCH: if (w_out_hs && w_last_rd) w_state_next = DRAIN;
            DRAIN:    if (r_busy == '0) w_state_next = FILL;
            default:  w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_count    <= '0;
            r_busy     <= '0;
            r_hold     <= 1'b0;
            r_hold_wid <= '0;
            r_batches  <= '0;
            r_txns     <= '0;
            r_stall    <= '0;
            r_forced   <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_hold  <= w_mvalid && !m_axis_tready;
            if (w_mvalid && !m_axis_tready) begin
                r_hold_wid <= w_wid;
            end
            if (w_in_hs) begin
                r_wr_idx <= r_wr_idx + 1'b1;
                if (w_close) begin
                    r_count <= r_wr_idx + 1'b1;
                end
                if (!s_axis_tlast && w_last_wr) begin
                    r_forced <= r_forced + 32'd1;
                end
            end
            if (w_out_hs) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                r_txns   <= r_txns + 32'd1;
            end
            if (w_stall) begin
                r_stall <= r_stall + 32'd1;
            end
            if (w_drain_done) begin
                r_batches <= r_batches + 32'd1;
                r_wr_idx  <= '0;
                r_rd_idx  <= '0;
                r_count   <= '0;
            end
        end
    end

    // Entry storage carries no reset; indices alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_buf[r_wr_idx[IDX_W-1:0]] <= s_axis_tdata_owner_programID;
        end
    end

endmodule

// File: tb/tb_batch_dispatcher.sv
// Bench for batch_dispatcher: a cycle table for a basic batch, directed corner sequences,
// and a randomized run scored against a queue-based model of the batch/barrier rules.
module tb_batch_dispatcher;

    localparam int MAXB = 8;
    localparam int NW   = 4;
    localparam int WW   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [63:0]   s_id;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [63:0]   m_id;
    logic [WW-1:0] m_wid;
    logic [NW-1:0] done;
    logic [NW-1:0] busy;
    logic          inflight;
    logic [31:0]   c_batches;
    logic [31:0]   c_txns;
    logic [31:0]   c_stall;
    logic [31:0]   c_forced;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    batch_dispatcher #(
        .MAX_BATCH_SIZE(MAXB),
        .NUM_WORKERS   (NW),
        .WID_W         (WW)
    ) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .s_axis_tvalid               (s_valid),
        .s_axis_tready               (s_ready),
        .s_axis_tdata_owner_programID(s_id),
        .s_axis_tlast                (s_last),
        .m_axis_tvalid               (m_valid),
        .m_axis_tready               (m_ready),
        .m_axis_tdata_owner_programID(m_id),
        .m_axis_tdata_worker_id      (m_wid),
        .worker_done                 (done),
        .worker_busy                 (busy),
        .batch_in_flight             (inflight),
        .batches_dispatched          (c_batches),
        .txns_dispatched             (c_txns),
        .dispatch_stall_cycles       (c_stall),
        .forced_closes               (c_forced)
    );

    typedef struct {
        logic        sv;
        logic        sl;
        logic [63:0] sid;
        logic        mr;
        logic [3:0]  dn;
        logic        e_str;
        logic        e_mv;
        logic [1:0]  e_wid;
        logic [63:0] e_mid;
        logic [3:0]  e_busy;
        logic        e_inf;
    } vec_t;

    vec_t tbl [10];

    // Randomized-run model state
    logic [63:0] pend_q [$];
    bit          collecting;
    int          beats;
    int          beats_left;
    logic [63:0] next_id;
    logic [3:0]  mb;
    logic [3:0]  nb;
    int          timer [NW];
    bit          held;
    logic [1:0]  hwid;
    logic [1:0]  ew;
    bit          exp_mv;
    bit          disp;
    bit          drain;
    bit          acc;
    int          m_txns;
    int          m_batches;
    int          m_forced;
    int          m_stall;
    int          cyc;
    bit          fc_ok;
    int          leaks;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_id    = '0;
        done    = '0;
    endtask

    function automatic logic [1:0] lowest_free(input logic [3:0] b);
        for (int i = 0; i < NW; i++) begin
            if (!b[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic do_reset();
        idle();
        m_ready = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tready_low", s_ready, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tready_high", s_ready, 1);
        chk("rst_wid", m_wid, 0);
        chk("rst_mid", m_id, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_cnt_a", {c_batches, c_txns}, 0);
        chk("rst_cnt_b", {c_stall, c_forced}, 0);
        nxt();
    endtask

    task automatic send(input logic [63:0] id, input logic last);
        s_valid = 1'b1;
        s_id    = id;
        s_last  = last;
        @(negedge clk);
        chk("send_tready", s_ready, 1);
        nxt();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        m_ready = 1'b0;
        idle();

        //          sv    sl    sid     mr    dn     str   mv    wid   mid     busy   inf
        tbl[0] = '{1'b1, 1'b0, 64'h10, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 64'h0,  4'h0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 64'h11, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 64'h0,  4'h0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 64'h12, 1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 64'h0,  4'h0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 64'h10, 4'h0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 64'h11, 4'h1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h0, 1'b0, 1'b1, 2'd2, 64'h12, 4'h3, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 64'h0,  4'h7, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h7, 1'b0, 1'b0, 2'd0, 64'h0,  4'h7, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 64'h0,  4'h0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 64'h0,  1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 64'h0,  4'h0, 1'b0};

        // Basic batch, one table row per cycle
        do_reset();
        for (int r = 0; r < 10; r++) begin
            s_valid = tbl[r].sv;
            s_last  = tbl[r].sl;
            s_id    = tbl[r].sid;
            m_ready = tbl[r].mr;
            done    = tbl[r].dn;
            @(negedge clk);
            chk($sformatf("tbl%0d_tready", r), s_ready, tbl[r].e_str);
            chk($sformatf("tbl%0d_mvalid", r), m_valid, tbl[r].e_mv);
            chk($sformatf("tbl%0d_wid", r), m_wid, tbl[r].e_wid);
            chk($sformatf("tbl%0d_mid", r), m_id, tbl[r].e_mid);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_inflight", r), inflight, tbl[r].e_inf);
            nxt();
        end
        idle();
        @(negedge clk);
        chk("basic_batches", c_batches, 1);
        chk("basic_txns", c_txns, 3);
        nxt();

        // Worker starvation
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(64'h20 + 64'(i), (i == 5));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("starve_mv", m_valid, 1);
            chk("starve_wid", m_wid, k);
            chk("starve_id", m_id, 64'h20 + 64'(k));
            nxt();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("starve_idle_mv", m_valid, 0);
            chk("starve_stall", c_stall, k);
            nxt();
        end
        done = 4'b0100;
        @(negedge clk);
        chk("starve_done_mv", m_valid, 0);
        nxt();
        done = '0;
        @(negedge clk);
        chk("starve_resume_mv", m_valid, 1);
        chk("starve_resume_wid", m_wid, 2);
        chk("starve_resume_id", m_id, 64'h24);
        chk("starve_stall_total", c_stall, 4);
        nxt();

        // Forced close: 9 beats without tlast
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(64'h30 + 64'(i), 1'b0);
        s_valid = 1'b1;
        s_id    = 64'h38;
        s_last  = 1'b0;
        @(negedge clk);
        chk("fc_forced", c_forced, 1);
        chk("fc_beat9_blocked", s_ready, 0);
        fc_ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            nxt();
            done = busy;
            @(negedge clk);
            if (s_ready) begin
                fc_ok = 1'b1;
                break;
            end
        end
        chk("fc_drained", fc_ok, 1);
        chk("fc_batches", c_batches, 1);
        chk("fc_txns", c_txns, 8);
        nxt();
        done   = '0;
        s_id   = 64'h39;
        s_last = 1'b1;
        @(negedge clk);
        chk("fc_beat10_tready", s_ready, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("fc_b2_mv", m_valid, 1);
        chk("fc_b2_wid0", m_wid, 0);
        chk("fc_b2_id0", m_id, 64'h38);
        chk("fc_forced_once", c_forced, 1);
        nxt();
        @(negedge clk);
        chk("fc_b2_wid1", m_wid, 1);
        chk("fc_b2_id1", m_id, 64'h39);
        nxt();

        // Backpressure with a lower lane freeing during the hold
        do_reset();
        m_ready = 1'b1;
        send(64'h40, 1'b0);
        send(64'h41, 1'b1);
        @(negedge clk);
        chk("bp_first_wid", m_wid, 0);
        chk("bp_first_id", m_id, 64'h40);
        nxt();
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            done = (c == 1) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk("bp_hold_mv", m_valid, 1);
            chk("bp_hold_wid", m_wid, 1);
            chk("bp_hold_id", m_id, 64'h41);
            nxt();
        end
        done    = '0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_wid", m_wid, 1);
        chk("bp_txns_before", c_txns, 1);
        nxt();
        @(negedge clk);
        chk("bp_txns_after", c_txns, 2);
        chk("bp_stall", c_stall, 5);
        chk("bp_drain_mv", m_valid, 0);
        chk("bp_drain_inflight", inflight, 1);
        nxt();

        // Barrier: lane 1 withholds done
        do_reset();
        m_ready = 1'b1;
        send(64'h50, 1'b0);
        send(64'h51, 1'b1);
        @(negedge clk);
        chk("bar_wid0", m_wid, 0);
        nxt();
        @(negedge clk);
        chk("bar_wid1", m_wid, 1);
        nxt();
        done = 4'b0001;
        @(negedge clk);
        chk("bar_busy", busy, 4'b0011);
        nxt();
        done    = '0;
        s_valid = 1'b1;
        s_id    = 64'h60;
        s_last  = 1'b1;
        leaks   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_ready || m_valid) leaks++;
            nxt();
        end
        chk("bar_blocked", leaks, 0);
        done = 4'b0010;
        @(negedge clk);
        chk("bar_done_tready", s_ready, 0);
        nxt();
        done = '0;
        @(negedge clk);
        chk("bar_idle_busy", busy, 0);
        chk("bar_idle_tready", s_ready, 0);
        nxt();
        @(negedge clk);
        chk("bar_fill_tready", s_ready, 1);
        chk("bar_batches", c_batches, 1);
        nxt();
        idle();
        @(negedge clk);
        chk("bar_b_mv", m_valid, 1);
        chk("bar_b_wid", m_wid, 0);
        chk("bar_b_id", m_id, 64'h60);
        nxt();

        // Reset in the middle of DISPATCH
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(64'h70 + 64'(i), (i == 3));
        @(negedge clk);
        chk("mr_wid0", m_wid, 0);
        nxt();
        @(negedge clk);
        chk("mr_wid1", m_wid, 1);
        nxt();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_tready_low", s_ready, 0);
        nxt();
        rst_n = 1'b1;
        done  = 4'b0011;
        @(negedge clk);
        chk("mr_mv", m_valid, 0);
        chk("mr_wid", m_wid, 0);
        chk("mr_id", m_id, 0);
        chk("mr_busy", busy, 0);
        chk("mr_inflight", inflight, 0);
        chk("mr_txns", c_txns, 0);
        chk("mr_tready", s_ready, 1);
        nxt();
        done = '0;
        @(negedge clk);
        chk("mr_stale_done", busy, 0);
        nxt();
        send(64'h7F, 1'b1);
        @(negedge clk);
        chk("mr_single_mv", m_valid, 1);
        chk("mr_single_wid", m_wid, 0);
        chk("mr_single_id", m_id, 64'h7F);
        nxt();

        // Randomized traffic against the batch/barrier model
        do_reset();
        pend_q.delete();
        collecting = 1'b1;
        beats      = 0;
        beats_left = 80;
        next_id    = 64'h1000;
        mb         = '0;
        held       = 1'b0;
        hwid       = '0;
        acc        = 1'b0;
        m_txns     = 0;
        m_batches  = 0;
        m_forced   = 0;
        m_stall    = 0;
        cyc        = 0;
        for (int i = 0; i < NW; i++) timer[i] = 0;
        while ((beats_left > 0 || s_valid || !collecting) && cyc < 6000) begin
            done = '0;
            for (int i = 0; i < NW; i++) begin
                if (mb[i]) begin
                    timer[i]--;
                    if (timer[i] <= 0) done[i] = 1'b1;
                end
            end
            if (acc) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            if (!s_valid && beats_left > 0 && $urandom_range(0, 9) < 6) begin
                s_valid = 1'b1;
                s_id    = next_id;
                next_id = next_id + 64'd1;
                beats_left--;
                s_last  = (beats_left == 0) || ($urandom_range(0, 3) == 0);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = 1'b0;
            chk("rnd_tready", s_ready, collecting);
            chk("rnd_busy", busy, mb);
            chk("rnd_inflight", inflight, !collecting);
            disp   = !collecting && (pend_q.size() > 0);
            drain  = !collecting && (pend_q.size() == 0) && (mb == '0);
            exp_mv = 1'b0;
            ew     = '0;
            if (disp) begin
                exp_mv = held || (mb != 4'hF);
                chk("rnd_mv", m_valid, exp_mv);
                if (exp_mv) begin
                    ew = held ? hwid : lowest_free(mb);
                    chk("rnd_wid", m_wid, ew);
                    chk("rnd_id", m_id, pend_q[0]);
                end
                if (mb == 4'hF || (exp_mv && !m_ready)) m_stall++;
            end else begin
                chk("rnd_mv_idle", m_valid, 0);
            end
            nb = mb & ~done;
            if (exp_mv && m_ready) begin
                void'(pend_q.pop_front());
                m_txns++;
                nb[ew]    = 1'b1;
                timer[ew] = $urandom_range(1, 10);
                held      = 1'b0;
            end else if (exp_mv) begin
                held = 1'b1;
                hwid = ew;
            end
            if (s_valid && collecting) begin
                acc = 1'b1;
                pend_q.push_back(s_id);
                beats++;
                if (s_last || beats == MAXB) begin
                    if (!s_last) m_forced++;
                    collecting = 1'b0;
                    beats      = 0;
                end
            end
            if (drain) begin
                collecting = 1'b1;
                m_batches++;
            end
            mb = nb;
            cyc++;
            nxt();
        end
        idle();
        chk("rnd_completed", (cyc < 6000), 1);
        @(negedge clk);
        chk("rnd_txns", c_txns, m_txns);
        chk("rnd_batches", c_batches, m_batches);
        chk("rnd_forced", c_forced, m_forced);
        chk("rnd_stall", c_stall, m_stall);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
